spi_rd_master: RTL and testbench
================================

# spi_rd_master

Initiator end of the 5-bit-address / 16-bit-data SPI read link: drives `spi_sck`, `spi_cs_n` and `spi_mosi` in mode 00 and collects the returned word and error line from the responder. It sits on the system side of the board link. It accepts one read request per handshake from the host logic and returns `rsp_data`/`rsp_err` with a one-cycle valid pulse. It also generates the chip-select-high sck pulse the responder needs to reset its state machine.

## Interface
- `CLK_DIV`, 2, system `clk` cycles per sck half-period (H); legal range 1..255
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  read request
- `req_addr`  in  5  word address, sent MSB first
- `req_ready`  out  1  high only in IDLE; a transfer starts on `req_valid && req_ready`
- `rsp_valid`  out  1  one-cycle pulse when `rsp_data`/`rsp_err` are valid
- `rsp_data`  out  16  received word; holds until the next `rsp_valid`
- `rsp_err`  out  1  responder error line captured at frame end
- `spi_sck`  out  1  serial clock, idle low
- `spi_cs_n`  out  1  chip select, idle high
- `spi_mosi`  out  1  to responder data input
- `spi_miso`  in  1  from responder data output
- `spi_err_i`  in  1  responder error flag (active high)

## Operation
- Reset values: `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, state IDLE. `req_ready`=1 once `rst_n` is high.
- All SPI outputs are registered. `req_ready` decodes state only.
- States:
  - IDLE → SYNC on accept; the address is latched into the shift register.
  - SYNC: `spi_cs_n`=1; sck low for H cycles, then high for H cycles. This is one rising edge with CS high, which forces the responder to its IDLE state and clears its error flag.
  - SETUP: `spi_cs_n`=0, sck low for H cycles.
  - SHIFT: 23 sck periods. Each period is high for H cycles, then low for H cycles. Rising edges are numbered r=1..23.
  - DONE: `spi_cs_n`=1, `rsp_valid`=1 for one cycle, then IDLE.
- MOSI:
  - Changes only while sck is low.
  - Before rising edge r=2..6 it carries `req_addr[6-r]` (A4 first).
  - It is 0 in every other phase.
- MISO:
  - Sampled at the clk edge that drives sck low after rising edge r=8..23.
  - The sample is shifted into bit 15 down to bit 0 (edge 8 gives D15, edge 23 gives D0).
  - Edges 1 and 7 are the responder's idle/read cycles; no data is sampled there.
- `rsp_err` = `spi_err_i` sampled together with D0.
- A new request is not accepted during DONE. Back-to-back requests are spaced by at least one IDLE cycle.
- Asynchronous reset at any point aborts the frame. Outputs return to reset values immediately; a partial word is never reported.

## Timing
- Accepting edge = edge 0. SYNC, SETUP and SHIFT occupy exactly 49·H cycles.
- `rsp_valid` is high in the cycle after edge 49·H: cycle 98 for H=2, cycle 49 for H=1.
- `req_ready` goes low at edge 0 and returns high at edge 49·H+1.
- `spi_cs_n` is low for 47·H cycles and falls H cycles after the last SYNC rising edge.
- MISO is sampled a half-period after the responder launches each bit; there is no synchronizer on `spi_miso`.
- Divider counter is ceil(log2(CLK_DIV)) bits wide (minimum 1). It reloads at every sck toggle and at every state entry.
- The edge counter is 5 bits and counts 1..23. It does not wrap.

## Structure
- Shared package `spi_pkg` holds:
  - state enum `spi_m_state_t` (IDLE, SYNC, SETUP, SHIFT, DONE)
  - constants ADDR_W=5, DATA_W=16, SPI_EDGES=23, FIRST_ADDR_EDGE=2, FIRST_DATA_EDGE=8
- Sub-module `spi_sck_gen`: half-period divider. It takes `clk`, `rst_n`, `run` and `CLK_DIV`, and produces the registered `sck`, plus one-cycle `rise` and `fall` strobes aligned to the toggling edge.
- The top-level FSM consumes those strobes.

## Test plan
- **Basic read:** reset, then request addr=5'b10110 with a behavioural responder returning 16'hA5C3 and err=0.
  - Required: MOSI bits 1,0,1,1,0 before edges 2..6.
  - Required: `rsp_data`=16'hA5C3, `rsp_err`=0, `rsp_valid` at cycle 98 (H=2).
- **Divider extremes:** CLK_DIV=1 and CLK_DIV=5, addr=0x1F, data=16'hFFFF.
  - Required: `rsp_valid` at cycles 49 and 245; exactly 24 sck rising edges per frame (1 SYNC + 23 SHIFT).
- **Error path:** responder err asserted with data 16'h0001.
  - Required: `rsp_err`=1, `rsp_data`=16'h0001.
  - Required: the next frame with err=0 returns `rsp_err`=0.
- **Handshake:** `req_valid` held high continuously with changing addresses.
  - Required: exactly one accept per frame, each accept ≥1 cycle after the previous `rsp_valid`, each address in its own frame.
- **Mid-frame reset:** assert `rst_n` low at cycle 40 of a frame.
  - Required: `spi_cs_n`=1, `spi_sck`=0 immediately; no `rsp_valid`.
  - Required: the following request reads correctly (16'h1234).
- **Protocol checker:** the bench asserts throughout every test that MOSI never changes while sck is high and that `spi_cs_n` never changes while sck is high.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants, state encoding and sizing helper for the SPI read link.
package spi_pkg;
  localparam int ADDR_W          = 5;
  localparam int DATA_W          = 16;
  localparam int SPI_EDGES       = 23;
  localparam int FIRST_ADDR_EDGE = 2;
  localparam int FIRST_DATA_EDGE = 8;

  typedef enum logic [2:0] {IDLE, SYNC, SETUP, SHIFT, DONE} spi_m_state_t;

  function automatic int div_cnt_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction
endpackage

// File: rtl/spi_sck_gen.sv
// Half-period divider: toggles sck every CLK_DIV cycles while run is high and
// flags the clk edge on which each toggle happens.
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic hold,
  output logic sck,
  output logic rise,
  output logic fall
);
  localparam int            CW     = div_cnt_w(CLK_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = run && (cnt == '0);
  assign rise = tick && !sck;
  assign fall = tick && sck;

  // hold keeps sck low but still reports the would-be rise, so the frame
  // owner can time its closing half-period without a second counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RELOAD;
      sck <= 1'b0;
    end else if (!run) begin
      cnt <= RELOAD;
      sck <= 1'b0;
    end else if (tick) begin
      cnt <= RELOAD;
      sck <= hold ? 1'b0 : ~sck;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/spi_rd_master.sv
// Mode-00 SPI read initiator: CS-high sync pulse, 5-bit address out, 16-bit
// word and error flag back, one-cycle response pulse per request.
module spi_rd_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              spi_sck,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso,
  input  logic              spi_err_i
);
  localparam logic [4:0] E_LAST = 5'(SPI_EDGES);
  localparam logic [4:0] E_A_LO = 5'(FIRST_ADDR_EDGE - 1);
  localparam logic [4:0] E_A_HI = 5'(FIRST_ADDR_EDGE - 1 + ADDR_W);
  localparam logic [4:0] E_D_LO = 5'(FIRST_DATA_EDGE);

  spi_m_state_t      state, state_nx;
  logic [4:0]        edge_cnt;
  logic [ADDR_W-1:0] addr_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              err_q;
  logic              run, hold, rise, fall;

  assign req_ready = (state == IDLE);
  assign run       = (state == SYNC) || (state == SETUP) || (state == SHIFT);
  assign hold      = (state == SHIFT) && (edge_cnt == E_LAST);

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .hold (hold),
    .sck  (spi_sck),
    .rise (rise),
    .fall (fall)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_valid) state_nx = SYNC;
      SYNC:    if (fall) state_nx = SETUP;
      SETUP:   if (rise) state_nx = SHIFT;
      SHIFT:   if (rise && hold) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      edge_cnt  <= '0;
      addr_sh   <= '0;
      rx_sh     <= '0;
      err_q     <= 1'b0;
      spi_cs_n  <= 1'b1;
      spi_mosi  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          addr_sh  <= req_addr;
          edge_cnt <= '0;
        end
        SYNC:  if (fall) spi_cs_n <= 1'b0;
        SETUP: if (rise) edge_cnt <= 5'd1;
        SHIFT: begin
          if (rise && !hold) edge_cnt <= edge_cnt + 5'd1;
          // the suppressed 24th rise closes the frame
          if (rise && hold) begin
            spi_cs_n  <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_data  <= rx_sh;
            rsp_err   <= err_q;
          end
          if (fall) begin
            // MOSI set up on the fall preceding rises 2..6, zero otherwise
            if (edge_cnt >= E_A_LO && edge_cnt < E_A_HI) begin
              spi_mosi <= addr_sh[ADDR_W-1];
              addr_sh  <= {addr_sh[ADDR_W-2:0], 1'b0};
            end else begin
              spi_mosi <= 1'b0;
            end
            if (edge_cnt >= E_D_LO) rx_sh <= {rx_sh[DATA_W-2:0], spi_miso};
            if (edge_cnt == E_LAST) err_q <= spi_err_i;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_rd_master.sv
// Scoreboarded bench for spi_rd_master at CLK_DIV = 2, 1 and 5 with a
// behavioural responder per instance.
module tb_spi_rd_master;
  localparam int NI = 3;

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
    logic        err;
    bit          set;    // overwrite responder memory before issuing
    bit          keep;   // leave req_valid high into the next request
    int          rst_at; // nonzero: reset this many cycles into the frame
  } plan_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got 0x%0h, want 0x%0h", nm, g, act, exp);
    end
  endtask

  task automatic fail_evt(input string nm, input int g, input string what);
    n_chk++;
    n_fail++;
    $display("FAIL %s inst%0d: got %s", nm, g, what);
  endtask

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int H = (g == 0) ? 2 : (g == 1) ? 1 : 5;
    localparam int BOUND = 60 * H + 20;

    logic        rst_n, req_valid, req_ready, rsp_valid, rsp_err;
    logic        sck, cs_n, mosi;
    logic        miso = 1'b0;
    logic        err_i = 1'b0;
    logic [4:0]  req_addr;
    logic [15:0] rsp_data;
    logic [15:0] mem [32];
    logic        errm [32];
    exp_t        sb [$];
    logic        fin = 1'b0;

    spi_rd_master #(.CLK_DIV(H)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_addr (req_addr),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid),
      .rsp_data (rsp_data),
      .rsp_err  (rsp_err),
      .spi_sck  (sck),
      .spi_cs_n (cs_n),
      .spi_mosi (mosi),
      .spi_miso (miso),
      .spi_err_i(err_i)
    );

    // Responder: CS-high rise resets it; rises 2..6 take the address, data
    // is launched on rises 8..23, error flag is presented from rise 7.
    int         r = 0;
    logic [4:0] raddr = '0;
    always @(posedge sck) begin
      if (cs_n) begin
        r = 0;
        err_i = 1'b0;
        miso = 1'b0;
      end else begin
        r++;
        if (r >= 2 && r <= 6) raddr = {raddr[3:0], mosi};
        miso = (r >= 8 && r <= 23) ? mem[raddr][23 - r] : 1'b0;
        if (r == 7) err_i = errm[raddr];
      end
    end

    // Monitor: protocol rules, handshake rules and scoreboard pops.
    int   cyc = 0, t_acc = 0, last_rsp = -100, rises = 0;
    bit   busy = 1'b0;
    logic psck = 1'b0, pmosi = 1'b0, pcs = 1'b1;
    always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!rst_n) begin
        busy = 1'b0;
        rises = 0;
      end else begin
        if (sck && !psck) rises++;
        if (mosi !== pmosi) check("mosi_change_sck_low", g, 32'(sck), 32'd0);
        if (cs_n !== pcs) check("cs_change_sck_low", g, 32'(sck), 32'd0);
        if (req_valid && req_ready) begin
          check("one_accept_per_frame", g, 32'(busy), 32'd0);
          check("accept_after_rsp", g, 32'(cyc > last_rsp), 32'd1);
          busy = 1'b1;
          t_acc = cyc;
          rises = 0;
        end
        if (rsp_valid) begin
          last_rsp = cyc;
          if (sb.size() == 0) begin
            fail_evt("rsp_unexpected", g, "rsp_valid with nothing outstanding");
          end else begin
            e = sb.pop_front();
            check("rsp_data", g, 32'(rsp_data), 32'(e.data));
            check("rsp_err", g, 32'(rsp_err), 32'(e.err));
            check("addr_seen_by_responder", g, 32'(raddr), 32'(e.addr));
            check("rsp_latency", g, 32'(cyc - t_acc), 32'(49 * H + 1));
            check("sck_rises_per_frame", g, 32'(rises), 32'd24);
          end
          busy = 1'b0;
        end
      end
      psck = sck;
      pmosi = mosi;
      pcs = cs_n;
    end

    // Stimulus: every plan item starts just after a rising clk edge.
    initial begin
      plan_t plan [$];
      plan_t p;
      exp_t  e;
      int    k;
      bit    seen;
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_addr = '0;
      for (int i = 0; i < 32; i++) begin
        mem[i] = 16'($urandom);
        errm[i] = 1'($urandom);
      end
      plan.push_back('{5'b10110, 16'hA5C3, 1'b0, 1'b1, 1'b0, 0});
      plan.push_back('{5'h1F, 16'hFFFF, 1'b0, 1'b1, 1'b0, 0});
      plan.push_back('{5'h03, 16'h0001, 1'b1, 1'b1, 1'b0, 0});
      plan.push_back('{5'h03, 16'h8000, 1'b0, 1'b1, 1'b0, 0});
      plan.push_back('{5'h0A, 16'hDEAD, 1'b1, 1'b1, 1'b0, 40});
      plan.push_back('{5'h0C, 16'h1234, 1'b0, 1'b1, 1'b0, 0});
      for (int i = 0; i < 6; i++)
        plan.push_back('{5'($urandom_range(0, 31)), 16'h0, 1'b0, 1'b0, 1'b0, 0});
      for (int i = 0; i < 5; i++)
        plan.push_back('{5'($urandom_range(0, 31)), 16'h0, 1'b0, 1'b0, (i != 4), 0});

      repeat (3) @(posedge clk);
      #1;
      check("rst_cs_n", g, 32'(cs_n), 32'd1);
      check("rst_sck", g, 32'(sck), 32'd0);
      check("rst_mosi", g, 32'(mosi), 32'd0);
      check("rst_rsp_valid", g, 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", g, 32'(rsp_data), 32'd0);
      check("rst_rsp_err", g, 32'(rsp_err), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_reset", g, 32'(req_ready), 32'd1);

      foreach (plan[i]) begin
        p = plan[i];
        if (p.set) begin
          mem[p.addr] = p.data;
          errm[p.addr] = p.err;
        end
        req_addr = p.addr;
        req_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < BOUND) begin
          @(negedge clk);
          k++;
        end
        if (!req_ready) begin
          fail_evt("accept_timeout", g, "req_ready never returned");
          req_valid = 1'b0;
          @(posedge clk);
          #1;
          continue;
        end
        if (p.rst_at == 0) begin
          e.addr = p.addr;
          e.data = mem[p.addr];
          e.err = errm[p.addr];
          sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!p.keep) req_valid = 1'b0;
        if (p.rst_at != 0) begin
          repeat (p.rst_at) @(posedge clk);
          #1;
          rst_n = 1'b0;
          #1;
          check("midrst_cs_n", g, 32'(cs_n), 32'd1);
          check("midrst_sck", g, 32'(sck), 32'd0);
          check("midrst_mosi", g, 32'(mosi), 32'd0);
          check("midrst_rsp_valid", g, 32'(rsp_valid), 32'd0);
          check("midrst_rsp_data", g, 32'(rsp_data), 32'd0);
          repeat (3) @(posedge clk);
          #1;
          rst_n = 1'b1;
          seen = 1'b0;
          repeat (50 * H) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
          end
          check("midrst_no_rsp", g, 32'(seen), 32'd0);
          @(posedge clk);
          #1;
        end else if (!p.keep) begin
          k = 0;
          while (sb.size() != 0 && k < BOUND) begin
            @(negedge clk);
            k++;
          end
          if (sb.size() != 0) begin
            fail_evt("rsp_timeout", g, "no rsp_valid within bound");
            sb.delete();
          end
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
      repeat (5) @(posedge clk);
      #1;
      fin = 1'b1;
    end
  end

  initial begin
    wait (gi[0].fin && gi[1].fin && gi[2].fin);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got no completion, want all instances finished");
    $fatal(1, "watchdog expired");
  end
endmodule
